// File: rtl/pipe_pkg.sv
// Shared pipeline types and widths for the memory / writeback stages.
package pipe_pkg;
    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_WAIT,
        MEM_ERR_DRAIN
    } mem_state_t;

    localparam int REG_ADDR_W = 4;
    localparam int DATA_W     = 32;
endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory handshake controller: tracks wait states, raises the stall,
// and abandons an access after TIMEOUT consecutive not-ready cycles.
module mem_access_fsm
    import pipe_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic memop_i,
    input  logic ready_i,
    output logic req_o,
    output logic stall_o,
    output logic drain_o,
    output logic timeout_o
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    mem_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy;

    // Request is gated by reset so it drops the instant reset asserts.
    assign busy      = memop_i & rst_n & (state_q != MEM_ERR_DRAIN);
    assign req_o     = busy;
    assign stall_o   = busy & ~ready_i;
    assign drain_o   = (state_q == MEM_ERR_DRAIN);

    // cnt_q counts not-ready cycles already spent on this access, so the
    // current cycle is wait number cnt_q+1; reaching TIMEOUT abandons it.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_o = 1'b0;
        case (state_q)
            MEM_IDLE, MEM_WAIT: begin
                if (!memop_i || ready_i) begin
                    state_d = MEM_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d   = MEM_ERR_DRAIN;
                    cnt_d     = CNT_W'(TIMEOUT);
                    timeout_o = 1'b1;
                end else begin
                    state_d = MEM_WAIT;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            MEM_ERR_DRAIN: begin
                state_d = MEM_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = MEM_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and wait-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MEM_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: rtl/mem_wb_stage.sv
// M stage + M->W pipeline register: holds the ALU result, drives the data
// memory port, and produces the writeback / PC-select signals.
module mem_wb_stage
    import pipe_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  PCSrcM,
    input  logic                  RegWriteM,
    input  logic                  MemtoRegM,
    input  logic                  MemWriteM,
    input  logic [DATA_W-1:0]     ALUResultE,
    input  logic [DATA_W-1:0]     WriteDataM,
    input  logic [REG_ADDR_W-1:0] WriteAddrM,
    input  logic                  dmem_ready,
    input  logic [DATA_W-1:0]     dmem_rdata,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [DATA_W-1:0]     dmem_addr,
    output logic [DATA_W-1:0]     dmem_wdata,
    output logic                  stallM,
    output logic [DATA_W-1:0]     ALUResultM,
    output logic                  RegWriteW,
    output logic                  PCSrcW,
    output logic [REG_ADDR_W-1:0] WriteAddrW,
    output logic [DATA_W-1:0]     ResultW,
    output logic                  mem_err
);
    logic              memop, illegal, drain, timeout;
    logic [DATA_W-1:0] alu_q, res_q;
    logic [REG_ADDR_W-1:0] waddr_q;
    logic              regw_q, pcsrc_q, err_q;

    assign memop   = MemtoRegM | MemWriteM;
    assign illegal = MemtoRegM & MemWriteM;

    mem_access_fsm #(.TIMEOUT(TIMEOUT)) u_fsm (
        .clk       (clk),
        .rst_n     (reset),
        .memop_i   (memop),
        .ready_i   (dmem_ready),
        .req_o     (dmem_req),
        .stall_o   (stallM),
        .drain_o   (drain),
        .timeout_o (timeout)
    );

    // Port side is combinational from M; forced to 0 while in reset.
    assign dmem_we    = MemWriteM & reset;
    assign dmem_addr  = reset ? alu_q : '0;
    assign dmem_wdata = reset ? WriteDataM : '0;

    assign ALUResultM = alu_q;
    assign RegWriteW  = regw_q;
    assign PCSrcW     = pcsrc_q;
    assign WriteAddrW = waddr_q;
    assign ResultW    = res_q;
    assign mem_err    = err_q;

    // M-stage ALU result advances whenever the stage is not stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       alu_q <= '0;
        else if (!stallM) alu_q <= ALUResultE;
    end

    // M->W register: stalled or abandoned ops retire as bubbles, data holds.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regw_q  <= 1'b0;
            pcsrc_q <= 1'b0;
            waddr_q <= '0;
            res_q   <= '0;
        end else if (stallM || drain) begin
            regw_q  <= 1'b0;
            pcsrc_q <= 1'b0;
        end else begin
            regw_q  <= RegWriteM & ~illegal;
            pcsrc_q <= PCSrcM;
            waddr_q <= WriteAddrM;
            res_q   <= MemtoRegM ? dmem_rdata : alu_q;
        end
    end

    // Sticky error: access timeout or simultaneous load+store.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                  err_q <= 1'b0;
        else if (timeout || illegal) err_q <= 1'b1;
    end
endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios followed by
// random ops, checked against an op-level reference model.
module tb_mem_wb_stage;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCSrcM, RegWriteM, MemtoRegM, MemWriteM;
    logic [31:0] ALUResultE, WriteDataM, dmem_rdata;
    logic [3:0]  WriteAddrM;
    logic        dmem_ready;
    logic        dmem_req, dmem_we, stallM, RegWriteW, PCSrcW, mem_err;
    logic [31:0] dmem_addr, dmem_wdata, ALUResultM, ResultW;
    logic [3:0]  WriteAddrW;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        ld, st, rw, pc;
        logic [3:0]  wa;
        logic [31:0] alu, wd, rd;
        int          waits;
    } op_t;

    // Reference state: last retired writeback values and sticky error.
    logic        exp_err;
    logic [3:0]  exp_wa;
    logic [31:0] exp_res;

    mem_wb_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .PCSrcM(PCSrcM), .RegWriteM(RegWriteM),
        .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM), .ALUResultE(ALUResultE),
        .WriteDataM(WriteDataM), .WriteAddrM(WriteAddrM), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .stallM(stallM),
        .ALUResultM(ALUResultM), .RegWriteW(RegWriteW), .PCSrcW(PCSrcW),
        .WriteAddrW(WriteAddrW), .ResultW(ResultW), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic op_t mk(input logic ld, st, rw, pc, input logic [3:0] wa,
                               input logic [31:0] alu, wd, rd, input int waits);
        op_t o;
        o.ld = ld; o.st = st; o.rw = rw; o.pc = pc; o.wa = wa;
        o.alu = alu; o.wd = wd; o.rd = rd; o.waits = waits;
        return o;
    endfunction

    function automatic op_t rnd_op();
        int kind;
        kind = $urandom_range(0, 9);
        // mostly ALU/load/store; occasionally an illegal load+store
        return mk(kind inside {[4:6], 9}, kind inside {[7:9]}, 1'($urandom),
                  1'($urandom), 4'($urandom), $urandom, $urandom, $urandom,
                  $urandom_range(0, 5));
    endfunction

    // Present one op for its whole M-stage lifetime and check it retires.
    // ALUResultE carries the following op's address (one stage ahead).
    task automatic run_op(input op_t op, input logic [31:0] next_alu);
        logic memop;
        bit   tmo;
        int   nst;
        memop = op.ld | op.st;
        tmo   = memop && (op.waits >= TO);
        nst   = !memop ? 0 : (tmo ? TO : op.waits);
        MemtoRegM = op.ld; MemWriteM = op.st; RegWriteM = op.rw; PCSrcM = op.pc;
        WriteAddrM = op.wa; WriteDataM = op.wd; dmem_rdata = op.rd;
        ALUResultE = next_alu;
        dmem_ready = memop ? (op.waits == 0) : 1'($urandom);
        for (int s = 0; s < nst; s++) begin
            @(negedge clk);
            chk("stall_hi", stallM, 1'b1);
            chk("req_hold", dmem_req, 1'b1);
            chk("we_hold", dmem_we, op.st);
            chk("addr_hold", dmem_addr, op.alu);
            chk("wdata_hold", dmem_wdata, op.wd);
            if (s > 0) chk("bubble_rw", RegWriteW, 1'b0);
            @(posedge clk); #1;
            dmem_ready = (s + 1 == op.waits);
        end
        @(negedge clk);
        chk("stall_lo", stallM, 1'b0);
        chk("req_final", dmem_req, memop && !tmo);
        chk("aluM", ALUResultM, op.alu);
        if (tmo) chk("drain_rw", RegWriteW, 1'b0);
        @(posedge clk); #1;
        if (op.ld && op.st) exp_err = 1'b1;
        if (tmo) begin
            exp_err = 1'b1;
            chk("tmo_rw", RegWriteW, 1'b0);
            chk("tmo_pc", PCSrcW, 1'b0);
        end else begin
            exp_wa  = op.wa;
            exp_res = op.ld ? op.rd : op.alu;
            chk("rw_W", RegWriteW, op.rw & ~(op.ld & op.st));
            chk("pc_W", PCSrcW, op.pc);
        end
        chk("wa_W", WriteAddrW, exp_wa);
        chk("res_W", ResultW, exp_res);
        chk("mem_err", mem_err, exp_err);
    endtask

    task automatic run_list(input op_t ops[$]);
        for (int i = 0; i < ops.size(); i++)
            run_op(ops[i], (i + 1 < ops.size()) ? ops[i+1].alu : 32'h0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"}, dmem_req, 1'b0);
        chk({tag, "_stall"}, stallM, 1'b0);
        chk({tag, "_we"}, dmem_we, 1'b0);
        chk({tag, "_addr"}, dmem_addr, 32'h0);
        chk({tag, "_wdata"}, dmem_wdata, 32'h0);
        chk({tag, "_aluM"}, ALUResultM, 32'h0);
        chk({tag, "_rw"}, RegWriteW, 1'b0);
        chk({tag, "_pc"}, PCSrcW, 1'b0);
        chk({tag, "_wa"}, WriteAddrW, 4'h0);
        chk({tag, "_res"}, ResultW, 32'h0);
        chk({tag, "_err"}, mem_err, 1'b0);
    endtask

    initial begin
        op_t ops[$];
        reset = 1'b0;
        PCSrcM = 0; RegWriteM = 0; MemtoRegM = 0; MemWriteM = 0;
        ALUResultE = 0; WriteDataM = 0; WriteAddrM = 0; dmem_ready = 0; dmem_rdata = 0;
        exp_err = 0; exp_wa = 0; exp_res = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        reset = 1'b1;

        // Directed: nop primer, ALU op, zero-wait load, 3-wait store,
        // timeout, follow-on op, back-to-back loads, illegal load+store.
        ops.push_back(mk(0, 0, 0, 0, 4'd0, 32'h0, 32'h0, 32'h0, 0));
        ops.push_back(mk(0, 0, 1, 0, 4'd5, 32'h2A, 32'h0, 32'h0, 0));
        ops.push_back(mk(1, 0, 1, 0, 4'd7, 32'h100, 32'h0, 32'hDEADBEEF, 0));
        ops.push_back(mk(0, 1, 0, 1, 4'd3, 32'h200, 32'hCAFEF00D, 32'h0, 3));
        ops.push_back(mk(1, 0, 1, 1, 4'd9, 32'h300, 32'h0, 32'h12345678, 6));
        ops.push_back(mk(0, 0, 1, 1, 4'd4, 32'h55, 32'h0, 32'h0, 0));
        ops.push_back(mk(1, 0, 1, 0, 4'd1, 32'h400, 32'h0, 32'h11111111, 0));
        ops.push_back(mk(1, 0, 1, 0, 4'd2, 32'h404, 32'h0, 32'h22222222, 0));
        ops.push_back(mk(1, 1, 1, 0, 4'd6, 32'h500, 32'hA5A5A5A5, 32'h66666666, 0));
        for (int i = 0; i < 40; i++) ops.push_back(rnd_op());
        run_list(ops);

        // Reset in the middle of a waiting store.
        exp_err = 1'b1;
        MemtoRegM = 0; MemWriteM = 1; RegWriteM = 1; WriteAddrM = 4'd8;
        WriteDataM = 32'hFACE; dmem_ready = 0; ALUResultE = 32'h77;
        @(posedge clk); #1;
        chk("pre_rst_err", mem_err, exp_err);
        @(posedge clk); #2;
        chk("pre_rst_stall", stallM, 1'b1);
        reset = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(posedge clk); #1;
        reset = 1'b1;
        exp_err = 0; exp_wa = 0; exp_res = 0;

        ops.delete();
        ops.push_back(mk(0, 0, 0, 0, 4'd0, 32'h0, 32'h0, 32'h0, 0));
        for (int i = 0; i < 20; i++) ops.push_back(rnd_op());
        run_list(ops);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
